// File: rtl/switch_debouncer_if.sv
// ---------------------------------------------------------------------------
// switch_debouncer_if
//
// Bundles the per-channel switch signals between the board-pin side and the
// debouncer. All vectors are N_CH bits wide, one bit per switch channel.
//
//   sw          raw switch pins (asynchronous to clk_50)
//   sw_level    debounced level
//   sw_rise     one-cycle pulse on an accepted 0->1 transition
//   sw_fall     one-cycle pulse on an accepted 1->0 transition
//   led         LED mirror of sw_level
//   chg_clr     clear for sticky change flags      (SW_STICKY_EN only)
//   sw_changed  sticky change flags                (SW_STICKY_EN only)
//
// Modports:
//   master  board / consumer side: drives the pins, reads the clean outputs
//   slave   the debouncer itself
//
// Optional feature macro: SW_STICKY_EN
// ---------------------------------------------------------------------------
interface switch_debouncer_if #(
    parameter int unsigned N_CH = 4
);

    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] sw_level;
    logic [N_CH-1:0] sw_rise;
    logic [N_CH-1:0] sw_fall;
    logic [N_CH-1:0] led;
`ifdef SW_STICKY_EN
    logic [N_CH-1:0] chg_clr;
    logic [N_CH-1:0] sw_changed;

    modport master (
        output sw,
        output chg_clr,
        input  sw_level,
        input  sw_rise,
        input  sw_fall,
        input  led,
        input  sw_changed
    );

    modport slave (
        input  sw,
        input  chg_clr,
        output sw_level,
        output sw_rise,
        output sw_fall,
        output led,
        output sw_changed
    );
`else
    modport master (
        output sw,
        input  sw_level,
        input  sw_rise,
        input  sw_fall,
        input  led
    );

    modport slave (
        input  sw,
        output sw_level,
        output sw_rise,
        output sw_fall,
        output led
    );
`endif

endinterface

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Front end for the board slide switches. Each of the N_CH raw, asynchronous
// switch inputs goes through a two-flop synchroniser and a per-channel
// debounce counter. A new level is accepted only after the synchronised input
// has disagreed with the current debounced level for DEBOUNCE_CYCLES
// consecutive cycles; any single agreeing cycle restarts the count.
//
// Parameters:
//   N_CH             number of switch channels (>= 1)
//   DEBOUNCE_CYCLES  consecutive mismatching cycles needed to accept a level
//                    (>= 1)
//   RESET_LEVEL      reset value of the synchroniser flops and debounced level
//
// Ports:
//   clk_50  50 MHz system clock, all logic on its rising edge
//   rst     synchronous, active-high reset
//   bus     switch_debouncer_if.slave: sw in; sw_level, sw_rise, sw_fall, led
//           out; with SW_STICKY_EN also chg_clr in and sw_changed out
//
// Optional feature macro: SW_STICKY_EN
//   Adds per-channel sticky change flags, set by a rise/fall pulse and cleared
//   by chg_clr. A set in the same cycle as a clear wins.
// ---------------------------------------------------------------------------
module switch_debouncer #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input logic               clk_50,
    input logic               rst,
    switch_debouncer_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    // Terminal count: reaching it with a mismatch still present accepts the level.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Synchroniser
    // -----------------------------------------------------------------------
    logic [N_CH-1:0] s1_q;
    logic [N_CH-1:0] s2_q;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            s1_q <= {N_CH{RESET_LEVEL}};
            s2_q <= {N_CH{RESET_LEVEL}};
        end else begin
            s1_q <= bus.sw;
            s2_q <= s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce counters and level
    // -----------------------------------------------------------------------
    logic [CntW-1:0] cnt_q [N_CH];
    logic [CntW-1:0] cnt_d [N_CH];
    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] level_d;
    logic [N_CH-1:0] rise_q;
    logic [N_CH-1:0] rise_d;
    logic [N_CH-1:0] fall_q;
    logic [N_CH-1:0] fall_d;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (s2_q[i] == level_q[i]) begin
                // Agreement (including a glitch back) restarts the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                cnt_d[i]   = '0;
                level_d[i] = s2_q[i];
                rise_d[i]  = s2_q[i];
                fall_d[i]  = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            level_q <= {N_CH{RESET_LEVEL}};
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.sw_level = level_q;
    assign bus.sw_rise  = rise_q;
    assign bus.sw_fall  = fall_q;
    // The LED is a straight mirror of the registered level.
    assign bus.led      = level_q;

    // -----------------------------------------------------------------------
    // Sticky change flags
    // -----------------------------------------------------------------------
`ifdef SW_STICKY_EN
    logic [N_CH-1:0] changed_q;
    logic [N_CH-1:0] changed_d;

    always_comb begin
        changed_d = changed_q;
        // Set from the visible pulses; set beats a simultaneous clear.
        changed_d = (rise_q | fall_q) | (changed_q & ~bus.chg_clr);
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            changed_q <= '0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign bus.sw_changed = changed_q;
`endif

endmodule
